// File: rtl/reg_host.sv
// Command-driven register host: write-fill, read-burst and go/wait operations
// against a device with a registered read port, returning responses over a
// valid/ready channel.
module reg_host #(
  parameter int DEPTH   = 5,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk_u,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [DEPTH-1:0] cmd_addr,
  input  logic [DEPTH-1:0] cmd_len,
  input  logic [31:0]      cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             rsp_err,
  output logic             dev_start,
  input  logic             dev_ready,
  output logic             dev_we,
  output logic [DEPTH-1:0] dev_addr,
  output logic [31:0]      dev_wdata,
  input  logic [31:0]      dev_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, WR, RD_ISS, RD_CAP, RD_RSP, GO_PULSE, GO_WAIT, RSP
  } state_t;

  state_t           state_q, state_d;
  logic [DEPTH-1:0] len_q, len_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_last_q, rsp_last_d;
  logic             rsp_err_q, rsp_err_d;
  logic             dev_start_q, dev_start_d;
  logic             dev_we_q, dev_we_d;
  logic [DEPTH-1:0] dev_addr_q, dev_addr_d;
  logic [31:0]      dev_wdata_q, dev_wdata_d;

  // Gated by rst so no command can be accepted in a reset cycle.
  assign cmd_ready = (state_q == IDLE) && !rst;

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_last  = rsp_last_q;
  assign rsp_err   = rsp_err_q;
  assign dev_start = dev_start_q;
  assign dev_we    = dev_we_q;
  assign dev_addr  = dev_addr_q;
  assign dev_wdata = dev_wdata_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_last_d  = rsp_last_q;
    rsp_err_d   = rsp_err_q;
    dev_start_d = dev_start_q;
    dev_we_d    = dev_we_q;
    dev_addr_d  = dev_addr_q;
    dev_wdata_d = dev_wdata_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          len_d = cmd_len;
          case (cmd_op)
            2'b00: begin
              state_d     = WR;
              dev_we_d    = 1'b1;
              dev_addr_d  = cmd_addr;
              dev_wdata_d = cmd_data;
            end
            2'b01: begin
              state_d    = RD_ISS;
              dev_addr_d = cmd_addr;
            end
            2'b10: begin
              state_d     = GO_PULSE;
              dev_start_d = 1'b1;
            end
            default: begin
              state_d     = RSP;
              rsp_valid_d = 1'b1;
              rsp_data_d  = '0;
              rsp_last_d  = 1'b1;
              rsp_err_d   = 1'b1;
            end
          endcase
        end
      end

      WR: begin
        if (len_q == '0) begin
          state_d     = RSP;
          dev_we_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_data_d  = '0;
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b0;
        end else begin
          dev_addr_d = dev_addr_q + DEPTH'(1);
          len_d      = len_q - DEPTH'(1);
        end
      end

      // Device read data for the address driven here arrives in RD_CAP.
      RD_ISS: state_d = RD_CAP;

      RD_CAP: begin
        state_d     = RD_RSP;
        rsp_valid_d = 1'b1;
        rsp_data_d  = dev_rdata;
        rsp_last_d  = (len_q == '0);
        rsp_err_d   = 1'b0;
      end

      RD_RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          if (len_q == '0) begin
            state_d = IDLE;
          end else begin
            state_d    = RD_ISS;
            dev_addr_d = dev_addr_q + DEPTH'(1);
            len_d      = len_q - DEPTH'(1);
          end
        end
      end

      // dev_ready is deliberately not looked at during the pulse cycle.
      GO_PULSE: begin
        state_d     = GO_WAIT;
        dev_start_d = 1'b0;
        cnt_d       = CW'(1);
      end

      GO_WAIT: begin
        if (dev_ready) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'(cnt_q);
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b0;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          state_d     = RSP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = 32'(TIMEOUT);
          rsp_last_d  = 1'b1;
          rsp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      RSP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_u) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      dev_start_q <= 1'b0;
      dev_we_q    <= 1'b0;
      dev_addr_q  <= '0;
      dev_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_last_q  <= rsp_last_d;
      rsp_err_q   <= rsp_err_d;
      dev_start_q <= dev_start_d;
      dev_we_q    <= dev_we_d;
      dev_addr_q  <= dev_addr_d;
      dev_wdata_q <= dev_wdata_d;
    end
  end

endmodule

// File: tb/tb_reg_host.sv
// Directed bench for reg_host: command table plus stall, reset and
// reset-mid-burst sequences against a registered-read device model.
module tb_reg_host;

  logic        clk_u = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [4:0]  cmd_addr;
  logic [4:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        rsp_err;
  logic        dev_start;
  logic        dev_ready;
  logic        dev_we;
  logic [4:0]  dev_addr;
  logic [31:0] dev_wdata;
  logic [31:0] dev_rdata;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_u = ~clk_u;

  reg_host #(.DEPTH(5), .TIMEOUT(16)) dut (
    .clk_u     (clk_u),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_last  (rsp_last),
    .rsp_err   (rsp_err),
    .dev_start (dev_start),
    .dev_ready (dev_ready),
    .dev_we    (dev_we),
    .dev_addr  (dev_addr),
    .dev_wdata (dev_wdata),
    .dev_rdata (dev_rdata)
  );

  // Registered-read device, preloaded with 0xC0DE0000+index on the first edge.
  logic [31:0] mem [32];
  bit          preloaded;
  always @(posedge clk_u) begin
    if (!preloaded) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hC0DE_0000 + i;
      preloaded <= 1'b1;
    end else if (dev_we) begin
      mem[dev_addr] <= dev_wdata;
    end
    dev_rdata <= mem[dev_addr];
  end

  // dev_ready goes high ready_delay cycles after dev_start (0 = never).
  int go_cnt = 0;
  int ready_delay = 0;
  always @(posedge clk_u) begin
    if (dev_start) go_cnt <= 1;
    else if (go_cnt != 0) go_cnt <= go_cnt + 1;
  end
  assign dev_ready = (ready_delay != 0) && (go_cnt >= ready_delay);

  int we_seen = 0;
  int start_seen = 0;
  always @(posedge clk_u) begin
    if (dev_we) we_seen <= we_seen + 1;
    if (dev_start) start_seen <= start_seen + 1;
  end

  typedef struct {
    string            name;
    logic [1:0]       op;
    logic [4:0]       addr;
    logic [4:0]       len;
    logic [31:0]      data;
    int               delay;
    int               n_rsp;
    logic [3:0][31:0] d;
    logic             err;
    int               n_we;
    int               n_start;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".cmd_ready"}, 32'(cmd_ready), 0);
    chk({tag, ".rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, ".rsp_data"},  rsp_data, 0);
    chk({tag, ".rsp_last"},  32'(rsp_last), 0);
    chk({tag, ".rsp_err"},   32'(rsp_err), 0);
    chk({tag, ".dev_start"}, 32'(dev_start), 0);
    chk({tag, ".dev_we"},    32'(dev_we), 0);
    chk({tag, ".dev_addr"},  32'(dev_addr), 0);
    chk({tag, ".dev_wdata"}, dev_wdata, 0);
  endtask

  task automatic send_cmd(input string name, input logic [1:0] op, input logic [4:0] addr,
                          input logic [4:0] len, input logic [31:0] data);
    int w;
    @(negedge clk_u);
    cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 20) begin
      @(negedge clk_u);
      w++;
    end
    if (!cmd_ready) chk({name, ".accept_timeout"}, 32'(cmd_ready), 1);
    @(posedge clk_u);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int k, we0, st0;
    ready_delay = v.delay;
    rsp_ready = 1'b1;
    we0 = we_seen;
    st0 = start_seen;
    send_cmd(v.name, v.op, v.addr, v.len, v.data);
    k = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk_u);
      if (rsp_valid) begin
        if (k < 4) begin
          chk($sformatf("%s.data%0d", v.name, k), rsp_data, v.d[k]);
          chk($sformatf("%s.last%0d", v.name, k), 32'(rsp_last), 32'(k == v.n_rsp - 1));
          chk($sformatf("%s.err%0d", v.name, k), 32'(rsp_err), 32'(v.err));
        end
        k++;
      end
    end
    chk({v.name, ".n_rsp"}, k, v.n_rsp);
    chk({v.name, ".n_we"}, we_seen - we0, v.n_we);
    chk({v.name, ".n_start"}, start_seen - st0, v.n_start);
    $display("vec %-10s op=%0d addr=%0d len=%0d -> %0d responses, %0d we, %0d start",
             v.name, v.op, v.addr, v.len, k, we_seen - we0, start_seen - st0);
  endtask

  task automatic set_vec(input int i, input string name, input logic [1:0] op,
                         input logic [4:0] addr, input logic [4:0] len, input logic [31:0] data,
                         input int delay, input int n_rsp, input logic err,
                         input int n_we, input int n_start);
    vecs[i].name = name;   vecs[i].op = op;       vecs[i].addr = addr;
    vecs[i].len = len;     vecs[i].data = data;   vecs[i].delay = delay;
    vecs[i].n_rsp = n_rsp; vecs[i].err = err;     vecs[i].n_we = n_we;
    vecs[i].n_start = n_start;
    vecs[i].d = '0;
  endtask

  initial begin
    vec_t extra;
    int   w, seen;

    set_vec(0, "wr_wrap",   2'b00, 5'd30, 5'd3, 32'hA5A5_0001, 0, 1, 1'b0, 4, 0);
    set_vec(1, "wr_31",     2'b00, 5'd31, 5'd0, 32'h0000_0011, 0, 1, 1'b0, 1, 0);
    set_vec(2, "wr_0",      2'b00, 5'd0,  5'd0, 32'h0000_0022, 0, 1, 1'b0, 1, 0);
    set_vec(3, "rd_wrap",   2'b01, 5'd31, 5'd1, 32'h0,         0, 2, 1'b0, 0, 0);
    vecs[3].d[0] = 32'h11; vecs[3].d[1] = 32'h22;
    set_vec(4, "go_7",      2'b10, 5'd0,  5'd0, 32'h0,         7, 1, 1'b0, 0, 1);
    vecs[4].d[0] = 32'd7;
    set_vec(5, "go_tmo",    2'b10, 5'd0,  5'd0, 32'h0,         0, 1, 1'b1, 0, 1);
    vecs[5].d[0] = 32'd16;
    set_vec(6, "reserved",  2'b11, 5'd3,  5'd2, 32'hFFFF_FFFF, 0, 1, 1'b1, 0, 0);
    set_vec(7, "go_1",      2'b10, 5'd0,  5'd0, 32'h0,         1, 1, 1'b0, 0, 1);
    vecs[7].d[0] = 32'd1;
    set_vec(8, "go_16",     2'b10, 5'd0,  5'd0, 32'h0,        16, 1, 1'b0, 0, 1);
    vecs[8].d[0] = 32'd16;
    set_vec(9, "rd_3",      2'b01, 5'd5,  5'd2, 32'h0,         0, 3, 1'b0, 0, 0);
    vecs[9].d[0] = 32'hC0DE_0005; vecs[9].d[1] = 32'hC0DE_0006; vecs[9].d[2] = 32'hC0DE_0007;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_len = '0;
    cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk_u);
    @(negedge clk_u);
    check_reset("reset");
    @(posedge clk_u);
    #1 rst = 1'b0;
    @(negedge clk_u);
    chk("cmd_ready_after_reset", 32'(cmd_ready), 1);

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);

    chk("mem30", mem[30], 32'hA5A5_0001);
    chk("mem1",  mem[1],  32'hA5A5_0001);
    chk("mem2",  mem[2],  32'hC0DE_0002);

    // Response stall: outputs and device address must hold.
    rsp_ready = 1'b0;
    send_cmd("stall", 2'b01, 5'd5, 5'd0, 32'h0);
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk_u);
      w++;
    end
    chk("stall.valid_seen", 32'(rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk_u);
      chk("stall.valid", 32'(rsp_valid), 1);
      chk("stall.data", rsp_data, 32'hC0DE_0005);
      chk("stall.last", 32'(rsp_last), 1);
      chk("stall.addr", 32'(dev_addr), 5);
      chk("stall.we", 32'(dev_we), 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk_u);
    chk("stall.released", 32'(rsp_valid), 0);
    chk("stall.idle", 32'(cmd_ready), 1);
    $display("seq stall: response held 5 cycles then released");

    // Reset during the second word of a read burst.
    send_cmd("rstmid", 2'b01, 5'd10, 5'd2, 32'h0);
    w = 0;
    while (!rsp_valid && w < 20) begin
      @(negedge clk_u);
      w++;
    end
    chk("rstmid.first", rsp_data, 32'hC0DE_000A);
    @(negedge clk_u);
    rst = 1'b1;
    @(negedge clk_u);
    check_reset("rstmid");
    @(posedge clk_u);
    #1 rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk_u);
      if (rsp_valid) seen++;
    end
    chk("rstmid.no_rsp", seen, 0);
    $display("seq rstmid: burst aborted by reset, %0d stray responses", seen);

    extra.name = "go_after"; extra.op = 2'b10; extra.addr = '0; extra.len = '0;
    extra.data = '0; extra.delay = 3; extra.n_rsp = 1; extra.d = '0;
    extra.d[0] = 32'd3; extra.err = 1'b0; extra.n_we = 0; extra.n_start = 1;
    run_vec(extra);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_host.md
REG_HOST -- requirements
Module: reg_host

Interface
REQ-001 SHALL have parameter DEPTH, default 5: device address width; SIZE = 2**DEPTH words.
REQ-002 SHALL have parameter TIMEOUT, default 1024: maximum wait cycles for device ready after start.
REQ-003 SHALL have ports:
- clk_u  in  1  clock, all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_op  in  2  00 write-fill, 01 read-burst, 10 go, 11 reserved.
- cmd_addr  in  DEPTH  start word address.
- cmd_len  in  DEPTH  word count minus 1.
- cmd_data  in  32  write data.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_data  out  32  read word, or go cycle count.
- rsp_last  out  1  final response of a command.
- rsp_err  out  1  timeout or reserved op.
- dev_start  out  1  one-cycle start pulse to device.
- dev_ready  in  1  device done, level.
- dev_we  out  1  device write enable.
- dev_addr  out  DEPTH  device address.
- dev_wdata  out  32  device write data.
- dev_rdata  in  32  device read data, registered, valid the cycle after dev_addr is presented.

Function
REQ-004 SHALL use states IDLE, WR, RD_ISS, RD_CAP, RD_RSP, GO_PULSE, GO_WAIT, RSP.
REQ-005 SHALL assert cmd_ready only in IDLE; a command is latched (op, addr, len, data) on acceptance.
REQ-006 SHALL, on write-fill, enter WR and drive dev_we=1, dev_wdata=cmd_data for len+1 consecutive cycles, dev_addr incrementing by 1 per cycle from cmd_addr.
REQ-007 SHALL wrap all address increments modulo SIZE (SIZE-1 -> 0).
REQ-008 SHALL, after the last write cycle, enter RSP with rsp_data=0, rsp_last=1, rsp_err=0.
REQ-009 SHALL, on read-burst, per word: RD_ISS drives dev_addr (dev_we=0); RD_CAP latches dev_rdata into rsp_data; RD_RSP holds rsp_valid=1 until rsp_ready.
REQ-010 SHALL set rsp_last=1 only on word len+1 of a read burst; after handshake of a non-last word go to RD_ISS with address+1; after last go to IDLE.
REQ-011 SHALL, on go, assert dev_start for exactly one cycle (GO_PULSE), then in GO_WAIT count cycles from 1 while sampling dev_ready.
REQ-012 SHALL leave GO_WAIT on first sampled dev_ready=1 with rsp_data=count, rsp_err=0; or when count reaches TIMEOUT with rsp_data=TIMEOUT, rsp_err=1; dev_ready sampled in the GO_PULSE cycle SHALL be ignored.
REQ-013 SHALL answer reserved op 11 with a single response rsp_err=1, rsp_data=0, rsp_last=1, without device activity.
REQ-014 SHALL hold rsp_data, rsp_last, rsp_err stable while rsp_valid=1 and rsp_ready=0; RSP returns to IDLE on handshake.
REQ-015 SHALL drive dev_we=0 in every state except WR and dev_start=0 except GO_PULSE.
REQ-016 SHALL ignore cmd_valid while not in IDLE; no command queueing.
REQ-017 SHALL achieve read throughput of one word per 3 cycles when rsp_ready is held high; write-fill one word per cycle.

Reset
REQ-018 SHALL, while rst=1, enter IDLE and drive cmd_ready=0, rsp_valid=0, rsp_data=0, rsp_last=0, rsp_err=0, dev_start=0, dev_we=0, dev_addr=0, dev_wdata=0; cmd_ready=1 from the first cycle after rst deasserts.
REQ-019 SHALL abort any in-progress command on rst with no response emitted; rst overrides all handshakes in the same cycle.

Verification
REQ-020 Write-fill addr=30, len=3, data=0xA5A5_0001 -> dev_we high 4 cycles at addresses 30,31,0,1; one response data=0, last=1, err=0.
REQ-021 Read-burst addr=31, len=1 against a modelled registered-read device preloaded 31:0x11, 0:0x22 -> responses 0x11 (last=0) then 0x22 (last=1).
REQ-022 Read with rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable, dev_addr unchanged, no extra device reads.
REQ-023 Go with dev_ready rising 7 cycles after dev_start -> single-cycle dev_start; response data=7, err=0; go with dev_ready never high, TIMEOUT=16 -> data=16, err=1.
REQ-024 Reserved op 11 -> response err=1, last=1; no dev_we or dev_start pulse.
REQ-025 rst asserted mid read-burst (second word) -> all outputs at reset values next cycle; no response; next command executes normally.
